// File: rtl/sh_reg_cmd_seq.sv
// Command sequencer: buffers load/shift/delay commands in a FIFO and replays them as
// registered control beats for the 8-bit shift register. Optional abort port: SH_REG_CMD_ABORT_EN.
module sh_reg_cmd_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [2:0]               cmd_amt,
    input  logic [3:0]               cmd_rep,
    input  logic [W-1:0]             cmd_data,
    output logic                     load,
    output logic                     shift_r_l,
    output logic [2:0]               sh,
    output logic                     sh_en,
    output logic [W-1:0]             d_in,
    output logic                     busy,
    output logic                     done,
`ifdef SH_REG_CMD_ABORT_EN
    input  logic                     abort,
    output logic                     aborted,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_SHR, OP_SHL} op_e;
    typedef enum logic {S_IDLE, S_EXEC} state_e;

    typedef struct packed {
        logic [1:0]   op;
        logic [2:0]   amt;
        logic [3:0]   rep;
        logic [W-1:0] data;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    cmd_t            wr_entry;
    cmd_t            head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push, pop, flush, fifo_empty;

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [2:0]      amt_q, amt_d;
    logic [W-1:0]    data_q, data_d;
    logic [3:0]      rep_q, rep_d;
    logic            last_beat;

    logic            load_q, load_d;
    logic            shr_q, shr_d;
    logic [2:0]      sh_q, sh_d;
    logic            sh_en_q, sh_en_d;
    logic [W-1:0]    d_in_q, d_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // ---------------- command FIFO ----------------
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign wr_entry   = '{op: cmd_op, amt: cmd_amt, rep: cmd_rep, data: cmd_data};

`ifdef SH_REG_CMD_ABORT_EN
    assign push = cmd_valid && cmd_ready && !abort;
`else
    assign push = cmd_valid && cmd_ready;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // ---------------- sequencer FSM ----------------
    assign last_beat = (op_q == OP_LOAD) || (rep_q <= 4'd1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        amt_d   = amt_q;
        data_d  = data_q;
        rep_d   = rep_q;
        pop     = 1'b0;
        flush   = 1'b0;
        load_d  = 1'b0;
        shr_d   = 1'b0;
        sh_d    = '0;
        sh_en_d = 1'b0;
        d_in_d  = d_in_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                busy_d = 1'b1;
                rep_d  = rep_q - 4'd1;
                case (op_q)
                    OP_LOAD: begin
                        load_d = 1'b1;
                        d_in_d = data_q;
                    end
                    OP_SHR: begin
                        sh_en_d = 1'b1;
                        shr_d   = 1'b1;
                        sh_d    = amt_q;
                    end
                    OP_SHL: begin
                        sh_en_d = 1'b1;
                        sh_d    = amt_q;
                    end
                    default: ;
                endcase
                if (last_beat) begin
                    done_d = 1'b1;
                    // Chain straight into the next queued command so beats stay back-to-back.
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            op_d   = op_e'(head.op);
            amt_d  = head.amt;
            data_d = head.data;
            rep_d  = (head.rep == 4'd0) ? 4'd1 : head.rep;
        end

`ifdef SH_REG_CMD_ABORT_EN
        if (abort) begin
            flush   = 1'b1;
            pop     = 1'b0;
            state_d = S_IDLE;
            op_d    = op_q;
            amt_d   = amt_q;
            data_d  = data_q;
            rep_d   = rep_q;
            load_d  = 1'b0;
            shr_d   = 1'b0;
            sh_d    = '0;
            sh_en_d = 1'b0;
            d_in_d  = d_in_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            amt_q   <= '0;
            data_q  <= '0;
            rep_q   <= '0;
            load_q  <= 1'b0;
            shr_q   <= 1'b0;
            sh_q    <= '0;
            sh_en_q <= 1'b0;
            d_in_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
            load_q  <= load_d;
            shr_q   <= shr_d;
            sh_q    <= sh_d;
            sh_en_q <= sh_en_d;
            d_in_q  <= d_in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SH_REG_CMD_ABORT_EN
    logic aborted_q;
    always_ff @(posedge clk) begin
        if (rst) aborted_q <= 1'b0;
        else     aborted_q <= abort;
    end
    assign aborted = aborted_q;
`endif

    assign load       = load_q;
    assign shift_r_l  = shr_q;
    assign sh         = sh_q;
    assign sh_en      = sh_en_q;
    assign d_in       = d_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_count = count_q;

endmodule
